// File: rtl/obc1_pkg.sv
// rtl/obc1_pkg.sv - OBC1 shared types, window offsets and table constants
package obc1_pkg;

    // Engine states; CLEAR is only reachable when OBC1_RESET_CLEAR_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD1    = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_CLEAR  = 3'd4
    } obc1_state_t;

    // Window offsets (SNES_ADDR[10:0]) of the indirect sprite-table ports
    localparam logic [10:0] OFS_P0   = 11'h7F0;
    localparam logic [10:0] OFS_P1   = 11'h7F1;
    localparam logic [10:0] OFS_P2   = 11'h7F2;
    localparam logic [10:0] OFS_P3   = 11'h7F3;
    localparam logic [10:0] OFS_HI   = 11'h7F4;
    localparam logic [10:0] OFS_BASE = 11'h7F5;
    localparam logic [10:0] OFS_IDX  = 11'h7F6;

    // High table sits 0x200 above the selected base; low base is $7C00
    localparam logic [10:0] HI_TABLE    = 11'h200;
    localparam logic [10:0] LO_BASE_DEF = 11'h400;

    // Translate a window offset into a RAM address using the current base/index
    function automatic logic [10:0] obc1_map(
        input logic [10:0] a,
        input logic [10:0] base,
        input logic [6:0]  index
    );
        logic [10:0] ent;
        logic [10:0] hi;
        ent = base + {2'b00, index, 2'b00};
        hi  = base + HI_TABLE + {6'b000000, index[6:2]};
        if (a[10:2] == OFS_P0[10:2]) begin
            obc1_map = ent + {9'b0, a[1:0]};
        end else if (a == OFS_HI) begin
            obc1_map = hi;
        end else begin
            obc1_map = a;
        end
    endfunction

endpackage

// File: rtl/obc1_ram.sv
// rtl/obc1_ram.sv - OBC1 private RAM, single port, 1-cycle synchronous read, write-first
module obc1_ram #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Registered read port; a write returns the new data on the same port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/obc1_ctrl.sv
// rtl/obc1_ctrl.sv - OBC1 OAM-window engine top; optional OBC1_RESET_CLEAR_EN zeroes RAM after reset
module obc1_ctrl
    import obc1_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [10:0] LO_BASE = LO_BASE_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        obc1_enable,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        SNES_RD_start,
    input  logic        SNES_WR_end,
    output logic [7:0]  DATA_OUT,
    output logic        busy,
    output logic        ovf
);

    obc1_state_t state_q, state_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        ovf_q, ovf_d;
    logic        base_sel_q, base_sel_d;
    logic [6:0]  index_q, index_d;
    logic [RAM_AW-1:0] hi_q, hi_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  bits_q, bits_d;
    logic [7:0]  merge_q, merge_d;
`ifdef OBC1_RESET_CLEAR_EN
    logic [RAM_AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic [RAM_AW-1:0] a;
    logic [RAM_AW-1:0] base;
    logic [RAM_AW-1:0] mapped;
    logic              rd_go;
    logic              wr_go;
    logic              ram_we;
    logic              ram_we_req;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^SNES_ADDR[23:11];

    // Strobe qualification and offset translation with the shadow regs as they stand now
    always_comb begin
        a      = SNES_ADDR[10:0];
        rd_go  = obc1_enable & SNES_RD_start;
        wr_go  = obc1_enable & SNES_WR_end;
        base   = base_sel_q ? 11'h000 : LO_BASE;
        mapped = obc1_map(a, base, index_q);
    end

    // Next-state, RAM port steering, shadow register and RMW merge logic
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        base_sel_d = base_sel_q;
        index_d    = index_q;
        hi_d       = hi_q;
        k_d        = k_q;
        bits_d     = bits_q;
        merge_d    = merge_q;
`ifdef OBC1_RESET_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
`endif
        ram_we_req = 1'b0;
        ram_addr   = mapped;
        ram_wdata  = SNES_DATA_IN;

        case (state_q)
            ST_IDLE: begin
                if (wr_go) begin
                    // A write wins a same-cycle collision; the read is lost
                    if (rd_go) begin
                        ovf_d = 1'b1;
                    end
                    if (a == OFS_HI) begin
                        // Read the high-table byte now, merge next cycle, write after
                        hi_d    = mapped;
                        k_d     = index_q[1:0];
                        bits_d  = SNES_DATA_IN[1:0];
                        state_d = ST_RMW_RD;
                    end else begin
                        ram_we_req = 1'b1;
                        if (a == OFS_BASE) begin
                            base_sel_d = SNES_DATA_IN[0];
                        end
                        if (a == OFS_IDX) begin
                            index_d = SNES_DATA_IN[6:0];
                        end
                    end
                end else if (rd_go) begin
                    state_d = ST_RD1;
                end
            end
            ST_RD1: begin
                data_out_d = ram_rdata;
                state_d    = ST_IDLE;
                if (rd_go || wr_go) begin
                    ovf_d = 1'b1;
                end
            end
            ST_RMW_RD: begin
                merge_d                   = ram_rdata;
                merge_d[{k_q, 1'b0} +: 2] = bits_q;
                state_d                   = ST_RMW_WR;
                if (rd_go || wr_go) begin
                    ovf_d = 1'b1;
                end
            end
            ST_RMW_WR: begin
                ram_we_req = 1'b1;
                ram_addr   = hi_q;
                ram_wdata  = merge_q;
                state_d    = ST_IDLE;
                if (rd_go || wr_go) begin
                    ovf_d = 1'b1;
                end
            end
`ifdef OBC1_RESET_CLEAR_EN
            ST_CLEAR: begin
                ram_we_req = 1'b1;
                ram_addr   = clr_cnt_q;
                ram_wdata  = 8'h00;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = ST_IDLE;
                end
                if (rd_go || wr_go) begin
                    ovf_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset aborts any RAM write in flight, including a pending RMW
        ram_we = ram_we_req & ~RST;
    end

    // State and shadow registers; reset leaves RAM contents alone
    always_ff @(posedge CLK) begin
        if (RST) begin
`ifdef OBC1_RESET_CLEAR_EN
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
`else
            state_q   <= ST_IDLE;
`endif
            data_out_q <= 8'h00;
            ovf_q      <= 1'b0;
            base_sel_q <= 1'b0;
            index_q    <= 7'h00;
            hi_q       <= '0;
            k_q        <= 2'b00;
            bits_q     <= 2'b00;
            merge_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
`ifdef OBC1_RESET_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            base_sel_q <= base_sel_d;
            index_q    <= index_d;
            hi_q       <= hi_d;
            k_q        <= k_d;
            bits_q     <= bits_d;
            merge_q    <= merge_d;
        end
    end

    obc1_ram #(
        .AW(RAM_AW),
        .DW(8)
    ) u_ram (
        .clk  (CLK),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign DATA_OUT = data_out_q;
    assign busy     = (state_q != ST_IDLE);
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_obc1_ctrl.sv
// tb/tb_obc1_ctrl.sv - randomized self-checking bench for obc1_ctrl against a transaction-level model
module tb_obc1_ctrl;

    logic        CLK;
    logic        RST;
    logic        obc1_enable;
    logic [23:0] SNES_ADDR;
    logic [7:0]  SNES_DATA_IN;
    logic        SNES_RD_start;
    logic        SNES_WR_end;
    logic [7:0]  DATA_OUT;
    logic        busy;
    logic        ovf;

    obc1_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .obc1_enable  (obc1_enable),
        .SNES_ADDR    (SNES_ADDR),
        .SNES_DATA_IN (SNES_DATA_IN),
        .SNES_RD_start(SNES_RD_start),
        .SNES_WR_end  (SNES_WR_end),
        .DATA_OUT     (DATA_OUT),
        .busy         (busy),
        .ovf          (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: RAM image plus the programmer-visible state
    logic [7:0] mem [0:2047];
    logic       msel;
    logic [6:0] midx;
    logic [7:0] mdout;
    logic       movf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [10:0] m_map(input logic [10:0] a);
        int base;
        int r;
        base = msel ? 0 : 'h400;
        if (a >= 11'h7F0 && a <= 11'h7F3) r = base + 4 * int'(midx) + (int'(a) - 'h7F0);
        else if (a == 11'h7F4)            r = base + 'h200 + int'(midx) / 4;
        else                              r = int'(a);
        return 11'(r % 2048);
    endfunction

    task automatic model_write(input logic [10:0] a, input logic [7:0] d);
        logic [10:0] h;
        logic [7:0]  v;
        int          k;
        h = m_map(a);
        if (a == 11'h7F4) begin
            k = int'(midx) % 4;
            v = mem[h];
            v[2*k +: 2] = d[1:0];
            mem[h] = v;
        end else begin
            mem[h] = d;
            if (a == 11'h7F5) msel = d[0];
            if (a == 11'h7F6) midx = d[6:0];
        end
    endtask

    task automatic set_addr(input logic [10:0] a);
        SNES_ADDR = {8'($urandom_range(0, 63)), 5'b01111, a};
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        msel  = 1'b0;
        midx  = 7'h00;
        mdout = 8'h00;
        movf  = 1'b0;
`ifdef OBC1_RESET_CLEAR_EN
        begin
            int n;
            n = 0;
            while (busy && n < 3000) begin
                cyc();
                n++;
            end
            check("clear_len", n, 2048);
            for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        end
`endif
    endtask

    task automatic do_wr(input logic [10:0] a, input logic [7:0] d);
        set_addr(a);
        SNES_DATA_IN = d;
        obc1_enable  = 1'b1;
        SNES_WR_end  = 1'b1;
        cyc();
        SNES_WR_end  = 1'b0;
        model_write(a, d);
        if (a == 11'h7F4) begin
            check("rmw_busy1", busy, 1);
            cyc();
            check("rmw_busy2", busy, 1);
            cyc();
            check("rmw_done", busy, 0);
        end else begin
            check("wr_busy", busy, 0);
        end
    endtask

    task automatic do_rd(input logic [10:0] a);
        set_addr(a);
        obc1_enable   = 1'b1;
        SNES_RD_start = 1'b1;
        cyc();
        SNES_RD_start = 1'b0;
        check("rd_busy", busy, 1);
        cyc();
        mdout = mem[m_map(a)];
        check("rd_data", DATA_OUT, mdout);
        check("rd_idle", busy, 0);
    endtask

    initial begin
        logic [10:0] a;
        logic [7:0]  d;
        RST = 1'b1;
        obc1_enable = 1'b0;
        SNES_ADDR = 24'h0;
        SNES_DATA_IN = 8'h00;
        SNES_RD_start = 1'b0;
        SNES_WR_end = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        do_reset();
        check("rst_dout", DATA_OUT, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
`ifdef OBC1_RESET_CLEAR_EN
        do_rd(11'h2BC);
        check("clear_7abc", DATA_OUT, 8'h00);
`endif

        // Give every reachable RAM byte a known value
        for (int i = 0; i < 2048; i++) begin
            if (i < 'h7F0 || i > 'h7F4) do_wr(11'(i), 8'($urandom));
        end

        // Indirect entry port with base $7C00
        do_wr(11'h7F6, 8'h05);
        do_wr(11'h7F5, 8'h00);
        do_wr(11'h7F1, 8'hAB);
        check("t1_ram415", mem[11'h415], 8'hAB);
        do_rd(11'h7F1);
        check("t1_rd", DATA_OUT, 8'hAB);

        // High-table read-modify-write
        do_wr(11'h601, 8'hFF);
        do_wr(11'h7F4, 8'h00);
        do_rd(11'h7F4);
        check("t2_hi", DATA_OUT, 8'hF3);

        // Base $7800, index 7F, then the plain path
        do_wr(11'h7F5, 8'h01);
        do_wr(11'h7F6, 8'h7F);
        do_wr(11'h7F3, 8'h5A);
        do_rd(11'h7F3);
        check("t3_rd", DATA_OUT, 8'h5A);
        do_rd(11'h003);

        // Read strobe while the RMW is busy is dropped
        d = 8'($urandom);
        set_addr(11'h7F4);
        SNES_DATA_IN = d;
        SNES_WR_end = 1'b1;
        cyc();
        SNES_WR_end = 1'b0;
        set_addr(11'h123);
        SNES_RD_start = 1'b1;
        cyc();
        SNES_RD_start = 1'b0;
        model_write(11'h7F4, d);
        movf = 1'b1;
        check("t4_ovf", ovf, 1);
        check("t4_busy", busy, 1);
        cyc();
        check("t4_done", busy, 0);
        check("t4_dout", DATA_OUT, mdout);
        do_rd(11'h7F4);

        // Reset during RMW_WR aborts the write (base 7C00, index 0 -> hi=600 survives reset)
        do_wr(11'h7F5, 8'h00);
        do_wr(11'h7F6, 8'h00);
        do_rd(11'h601);
        set_addr(11'h7F4);
        SNES_DATA_IN = ~mem[11'h600];
        SNES_WR_end = 1'b1;
        cyc();
        SNES_WR_end = 1'b0;
        cyc();
        do_reset();
        check("t5_busy", busy, 0);
        check("t5_dout", DATA_OUT, 0);
        check("t5_ovf", ovf, 0);
        do_rd(11'h7F4);
        obc1_enable = 1'b0;
        SNES_RD_start = 1'b1;
        cyc();
        SNES_RD_start = 1'b0;
        check("t5_dis_ovf", ovf, 0);
        check("t5_dis_busy", busy, 0);
        check("t5_dis_dout", DATA_OUT, mdout);

        // Same-cycle read and write: write wins, read dropped
        a = 11'h155;
        d = 8'($urandom);
        set_addr(a);
        SNES_DATA_IN = d;
        obc1_enable = 1'b1;
        SNES_RD_start = 1'b1;
        SNES_WR_end = 1'b1;
        cyc();
        SNES_RD_start = 1'b0;
        SNES_WR_end = 1'b0;
        model_write(a, d);
        movf = 1'b1;
        check("both_ovf", ovf, 1);
        check("both_busy", busy, 0);
        do_rd(a);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 5) a = 11'h7F0 + 11'($urandom_range(0, 6));
            else       a = 11'($urandom_range(0, 2047));
            if (r < 3 || r == 5 || r == 6) begin
                if (r < 3) do_wr(a, d);
                else       do_rd(a);
            end else if (r == 3 || r == 4) begin
                do_wr(11'($urandom_range(0, 2047)) | 11'h000, d);
            end else if (r == 7 || r == 8) begin
                do_rd(a);
            end else begin
                set_addr(a);
                SNES_DATA_IN = d;
                obc1_enable = 1'b0;
                if ($urandom_range(0, 1) == 1) SNES_RD_start = 1'b1;
                else                           SNES_WR_end = 1'b1;
                cyc();
                SNES_RD_start = 1'b0;
                SNES_WR_end = 1'b0;
                check("dis_dout", DATA_OUT, mdout);
                check("dis_busy", busy, 0);
            end
            check("rand_ovf", ovf, movf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
